// File: rtl/ls_pkg.sv
// ls_pkg: shared opcodes, funct3 codes and FSM state encoding for the
// load/store unit.
package ls_pkg;

  localparam logic [6:0] OPCODE_L = 7'b0000011;
  localparam logic [6:0] OPCODE_S = 7'b0100011;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    WB     = 2'd3
  } ls_state_e;

endpackage

// File: rtl/ls_align.sv
// ls_align: combinational byte-lane logic. Places store data on the lanes
// selected by the address offset and extracts/extends load results.
// Halfwords use off[1] only; words ignore the offset.
module ls_align
  import ls_pkg::*;
(
  input  logic [2:0]  funct,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane steering for stores and extraction for loads
  always_comb begin
    wstrb     = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    byte_sel  = load_word[7:0];
    half_sel  = off[1] ? load_word[31:16] : load_word[15:0];

    case (off)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase

    case (funct)
      F_B: begin
        wstrb = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      F_H: begin
        wstrb = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase

    case (funct)
      F_B:     load_data = {{24{byte_sel[7]}}, byte_sel};
      F_BU:    load_data = {24'd0, byte_sel};
      F_H:     load_data = {{16{half_sel[15]}}, half_sel};
      F_HU:    load_data = {16'd0, half_sel};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/ls_unit.sv
// ls_unit: single-outstanding RV32I load/store unit. Issues one access to a
// single-port data memory and retires a completion record on a valid/ready
// write-back port.
// Optional build macro LS_MISALIGN_CHECK_EN: misaligned half/word accesses
// skip memory, retire with no register write and raise wb_err.
//
// state  | meaning
// IDLE   | waiting for ls_valid
// REQ    | mem_req held until mem_gnt
// WAIT_R | load granted, waiting for mem_rvalid
// WB     | completion presented until wb_ready
module ls_unit
  import ls_pkg::*;
#(
  parameter int SB_SIZE_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ls_valid,
  input  logic [6:0]               ls_opt,
  input  logic [2:0]               ls_funct,
  input  logic [4:0]               ls_rd,
  input  logic [DATA_WIDTH-1:0]    ls_imm,
  input  logic [SB_SIZE_WIDTH-1:0] ls_pos,
  input  logic [DATA_WIDTH-1:0]    rs1_val,
  input  logic [DATA_WIDTH-1:0]    rs2_val,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [SB_SIZE_WIDTH-1:0] wb_pos,
  output logic [4:0]               wb_rd,
  output logic                     wb_we,
  output logic [DATA_WIDTH-1:0]    wb_data,
`ifdef LS_MISALIGN_CHECK_EN
  output logic                     wb_err,
`endif
  output logic                     ls_idle
);

  ls_state_e state, state_nxt;

  logic [SB_SIZE_WIDTH-1:0] pos_q;
  logic [4:0]               rd_q;
  logic [2:0]               funct_q;
  logic                     is_load_q;
  logic                     is_store_q;
  logic                     err_q;
  logic [1:0]               off_q;
  logic [DATA_WIDTH-1:0]    rs2_q;
  logic [DATA_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    data_q;

  logic [DATA_WIDTH-1:0]    addr_sum;
  logic                     is_mem_in;
  logic                     misalign_in;
  logic                     reg_write_ok;
  logic [3:0]               al_wstrb;
  logic [31:0]              al_wdata;
  logic [31:0]              al_load;

  assign addr_sum  = rs1_val + ls_imm;
  assign is_mem_in = (ls_opt == OPCODE_L) || (ls_opt == OPCODE_S);

  // Alignment check of the incoming access (constant 0 when disabled)
  always_comb begin
    misalign_in = 1'b0;
`ifdef LS_MISALIGN_CHECK_EN
    case (ls_funct)
      F_B, F_BU: misalign_in = 1'b0;
      F_H, F_HU: misalign_in = addr_sum[0];
      default:   misalign_in = (addr_sum[1:0] != 2'b00);
    endcase
`endif
  end

  ls_align u_align (
    .funct      (funct_q),
    .off        (off_q),
    .store_data (rs2_q),
    .load_word  (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ls_valid) state_nxt = (is_mem_in && !misalign_in) ? REQ : WB;
      end
      REQ: begin
        if (mem_gnt) state_nxt = (is_load_q && !mem_rvalid) ? WAIT_R : WB;
      end
      WAIT_R: begin
        if (mem_rvalid) state_nxt = WB;
      end
      WB: begin
        if (wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction capture at issue and load result capture on rvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      off_q      <= '0;
      rs2_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_valid) begin
            pos_q      <= ls_pos;
            rd_q       <= ls_rd;
            funct_q    <= ls_funct;
            is_load_q  <= (ls_opt == OPCODE_L);
            is_store_q <= (ls_opt == OPCODE_S);
            err_q      <= is_mem_in && misalign_in;
            off_q      <= addr_sum[1:0];
            rs2_q      <= rs2_val;
            addr_q     <= {addr_sum[DATA_WIDTH-1:2], 2'b00};
            data_q     <= '0;
          end
        end
        REQ: begin
          if (mem_gnt && mem_rvalid && is_load_q) data_q <= al_load;
        end
        WAIT_R: begin
          if (mem_rvalid) data_q <= al_load;
        end
        default: ;
      endcase
    end
  end

  // A register write only happens for a load that reached memory
  assign reg_write_ok = is_load_q && !err_q;

  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) && is_store_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = mem_we ? al_wstrb : 4'b0000;
  assign mem_wdata = mem_we ? al_wdata : '0;

  assign wb_valid  = (state == WB);
  assign wb_pos    = wb_valid ? pos_q : '0;
  assign wb_rd     = (wb_valid && reg_write_ok) ? rd_q : '0;
  assign wb_we     = wb_valid && reg_write_ok && (rd_q != 5'd0);
  assign wb_data   = (wb_valid && reg_write_ok) ? data_q : '0;
  assign ls_idle   = (state == IDLE);

`ifdef LS_MISALIGN_CHECK_EN
  assign wb_err    = wb_valid && err_q;
`endif

endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: scoreboard bench for ls_unit with a small memory responder.
module tb_ls_unit;

  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;

  typedef struct {
    logic [3:0]  pos;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ls_valid;
  logic [6:0]  ls_opt;
  logic [2:0]  ls_funct;
  logic [4:0]  ls_rd;
  logic [31:0] ls_imm;
  logic [3:0]  ls_pos;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_pos;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        ls_idle;
`ifdef LS_MISALIGN_CHECK_EN
  logic        wb_err;
`endif

  int checks   = 0;
  int failures = 0;

  exp_t        sb_q[$];
  logic [31:0] mem [0:255];

  int          gnt_delay = 0;
  int          rv_delay  = 0;
  int          req_cnt   = 0;
  int          rv_cnt    = 0;
  logic        pend      = 1'b0;
  logic [31:0] pend_word = '0;
  logic [31:0] hold_addr = '0;
  int          req_cycles = 0;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_wstrb;
  logic        g_we;
  logic        wb_seen = 1'b0;

  ls_unit #(.SB_SIZE_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ls_valid   (ls_valid),
    .ls_opt     (ls_opt),
    .ls_funct   (ls_funct),
    .ls_rd      (ls_rd),
    .ls_imm     (ls_imm),
    .ls_pos     (ls_pos),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_pos     (wb_pos),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .wb_data    (wb_data),
`ifdef LS_MISALIGN_CHECK_EN
    .wb_err     (wb_err),
`endif
    .ls_idle    (ls_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] pos, input logic [4:0] rd, input logic we,
                              input logic [31:0] data, input logic err);
    exp_t e;
    e.pos = pos; e.rd = rd; e.we = we; e.data = data; e.err = err;
    return e;
  endfunction

  // Memory responder: grant after gnt_delay REQ cycles, read data rv_delay cycles after grant
  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (rst) begin
      pend    = 1'b0;
      req_cnt = 0;
    end else begin
      if (pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_word;
          pend       = 1'b0;
        end else begin
          rv_cnt--;
        end
      end
      if (mem_req) begin
        req_cycles++;
        if (req_cnt > 0) check("req_addr_stable", mem_addr, hold_addr);
        hold_addr = mem_addr;
        if (req_cnt == gnt_delay) begin
          mem_gnt = 1'b1;
          req_cnt = 0;
          g_addr  = mem_addr;
          g_we    = mem_we;
          g_wstrb = mem_wstrb;
          g_wdata = mem_wdata;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end else if (rv_delay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[mem_addr[9:2]];
          end else begin
            pend      = 1'b1;
            rv_cnt    = rv_delay - 1;
            pend_word = mem[mem_addr[9:2]];
          end
        end else begin
          req_cnt++;
        end
      end
    end
  end

  // Write-back monitor: pop and compare on every accepted completion
  always @(negedge clk) begin
    if (!rst && wb_valid) wb_seen = 1'b1;
    if (!rst && wb_valid && wb_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_wb", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_pos",  wb_pos,  e.pos);
        check("wb_rd",   wb_rd,   e.rd);
        check("wb_we",   wb_we,   e.we);
        check("wb_data", wb_data, e.data);
`ifdef LS_MISALIGN_CHECK_EN
        check("wb_err",  wb_err,  e.err);
`endif
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge later
  task automatic issue(input logic [6:0] opt, input logic [2:0] funct, input logic [4:0] rd,
                       input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                       input logic [3:0] pos, input exp_t e);
    check("idle_at_issue", ls_idle, 1'b1);
    ls_valid = 1'b1;
    ls_opt   = opt;
    ls_funct = funct;
    ls_rd    = rd;
    rs1_val  = rs1;
    ls_imm   = imm;
    rs2_val  = rs2;
    ls_pos   = pos;
    sb_q.push_back(e);
    @(negedge clk);
    ls_valid = 1'b0;
  endtask

  task automatic wait_wb(output int lat);
    lat = 1;
    while (!wb_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!wb_valid) check("wb_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   mem_req,   1'b0);
    check({tag, "_mem_we"},    mem_we,    1'b0);
    check({tag, "_mem_addr"},  mem_addr,  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wstrb"}, mem_wstrb, 4'd0);
    check({tag, "_wb_valid"},  wb_valid,  1'b0);
    check({tag, "_wb_pos"},    wb_pos,    4'd0);
    check({tag, "_wb_rd"},     wb_rd,     5'd0);
    check({tag, "_wb_we"},     wb_we,     1'b0);
    check({tag, "_wb_data"},   wb_data,   32'd0);
    check({tag, "_ls_idle"},   ls_idle,   1'b1);
`ifdef LS_MISALIGN_CHECK_EN
    check({tag, "_wb_err"},    wb_err,    1'b0);
`endif
  endtask

  initial begin
    int lat;
    int req_before;

    rst = 1'b1; ls_valid = 1'b0; ls_opt = '0; ls_funct = '0; ls_rd = '0;
    ls_imm = '0; ls_pos = '0; rs1_val = '0; rs2_val = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h80] = 32'h80FF_0000;
    mem[8'hC0] = 32'h8001_1234;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // SW, grant on second REQ cycle
    gnt_delay = 1; rv_delay = 0;
    issue(OP_S, 3'b010, 5'd5, 32'h100, 32'd4, 32'hDEAD_BEEF, 4'd9, mk(4'd9, 5'd0, 1'b0, 32'd0, 1'b0));
    wait_wb(lat);
    check("sw_latency", lat, 32'd3);
    check("sw_addr",  g_addr,  32'h104);
    check("sw_we",    g_we,    1'b1);
    check("sw_wstrb", g_wstrb, 4'b1111);
    check("sw_wdata", g_wdata, 32'hDEAD_BEEF);
    wait_done();

    // LW read-back, rvalid one cycle after grant
    gnt_delay = 0; rv_delay = 1;
    issue(OP_L, 3'b010, 5'd7, 32'h100, 32'd4, 32'd0, 4'd3, mk(4'd3, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b0));
    wait_wb(lat);
    check("lw_latency", lat, 32'd3);
    wait_done();

    // LB / LBU at 0x203, same-cycle rvalid
    rv_delay = 0;
    issue(OP_L, 3'b000, 5'd10, 32'h200, 32'd3, 32'd0, 4'd1, mk(4'd1, 5'd10, 1'b1, 32'hFFFF_FF80, 1'b0));
    wait_wb(lat);
    check("lb_latency", lat, 32'd2);
    check("lb_addr", g_addr, 32'h200);
    check("lb_we", g_we, 1'b0);
    wait_done();
    issue(OP_L, 3'b100, 5'd11, 32'h200, 32'd3, 32'd0, 4'd2, mk(4'd2, 5'd11, 1'b1, 32'h0000_0080, 1'b0));
    wait_done();

    // LH / LHU at 0x302 via negative offset
    issue(OP_L, 3'b001, 5'd12, 32'h310, 32'hFFFF_FFF2, 32'd0, 4'd4, mk(4'd4, 5'd12, 1'b1, 32'hFFFF_8001, 1'b0));
    wait_done();
    issue(OP_L, 3'b101, 5'd13, 32'h310, 32'hFFFF_FFF2, 32'd0, 4'd5, mk(4'd5, 5'd13, 1'b1, 32'h0000_8001, 1'b0));
    wait_done();

    // SH at 0x302
    issue(OP_S, 3'b001, 5'd1, 32'h302, 32'd0, 32'h0000_ABCD, 4'd6, mk(4'd6, 5'd0, 1'b0, 32'd0, 1'b0));
    wait_done();
    check("sh_addr",  g_addr,  32'h300);
    check("sh_wstrb", g_wstrb, 4'b1100);
    check("sh_wdata", g_wdata, 32'hABCD_ABCD);

    // Backpressure on write-back
    wb_ready = 1'b0;
    issue(OP_L, 3'b010, 5'd4, 32'h104, 32'd0, 32'd0, 4'd6, mk(4'd6, 5'd4, 1'b1, 32'hDEAD_BEEF, 1'b0));
    wait_wb(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", wb_valid, 1'b1);
      check("bp_pos",   wb_pos,   4'd6);
      check("bp_rd",    wb_rd,    5'd4);
      check("bp_data",  wb_data,  32'hDEAD_BEEF);
      check("bp_idle",  ls_idle,  1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle",  ls_idle,  1'b1);
    check("bp_release_valid", wb_valid, 1'b0);
    // New op accepted right away: SB at 0x201
    issue(OP_S, 3'b000, 5'd2, 32'h200, 32'd1, 32'h1234_5677, 4'd7, mk(4'd7, 5'd0, 1'b0, 32'd0, 1'b0));
    wait_done();
    check("sb_addr",  g_addr,  32'h200);
    check("sb_wstrb", g_wstrb, 4'b0010);
    check("sb_wdata", g_wdata, 32'h7777_7777);

    // Load with rd = 0
    issue(OP_L, 3'b010, 5'd0, 32'h104, 32'd0, 32'd0, 4'd2, mk(4'd2, 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b0));
    wait_done();

    // Non load/store opcode retires without memory access
    req_before = req_cycles;
    issue(OP_R, 3'b010, 5'd3, 32'h100, 32'd0, 32'd0, 4'd11, mk(4'd11, 5'd0, 1'b0, 32'd0, 1'b0));
    wait_done();
    check("other_op_no_req", req_cycles, req_before);

`ifdef LS_MISALIGN_CHECK_EN
    req_before = req_cycles;
    issue(OP_L, 3'b010, 5'd9, 32'h100, 32'd1, 32'd0, 4'd5, mk(4'd5, 5'd0, 1'b0, 32'd0, 1'b1));
    wait_wb(lat);
    check("mis_wb_err", wb_err, 1'b1);
    check("mis_wb_we",  wb_we,  1'b0);
    wait_done();
    check("mis_no_req", req_cycles, req_before);
`endif

    // Reset during WAIT_R abandons the load
    rv_delay = 20;
    issue(OP_L, 3'b010, 5'd8, 32'h104, 32'd0, 32'd0, 4'd12, mk(4'd12, 5'd8, 1'b1, 32'hDEAD_BEEF, 1'b0));
    @(negedge clk);
    check("waitr_idle", ls_idle, 1'b0);
    check("waitr_req",  mem_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    sb_q.delete();
    wb_seen = 1'b0;
    rv_delay = 0;
    repeat (25) @(negedge clk);
    check("no_wb_after_reset", wb_seen, 1'b0);

    // Recovery after reset
    issue(OP_L, 3'b010, 5'd15, 32'h104, 32'd0, 32'd0, 4'd13, mk(4'd13, 5'd15, 1'b1, 32'hDEAD_BEEF, 1'b0));
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
